// File: rtl/prime_gen_if.sv
// Handshake and data bundle between the prime enumerator and its user.
// The master side drives the request and consumer handshake; the slave
// side (prime_gen) returns primes, status and the accepted-prime count.
`timescale 1ns/1ps

interface prime_gen_if;
  logic       start;
  logic [8:0] limit;
  logic [8:0] prime;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       done;
  logic [6:0] count;

  modport master (
    output start, limit, ready,
    input  prime, valid, busy, done, count
  );

  modport slave (
    input  start, limit, ready,
    output prime, valid, busy, done, count
  );
endinterface

// File: rtl/prime_gen.sv
// Enumerates every prime from 2 up to an inclusive 9-bit limit, in order,
// by trial division with repeated subtraction. Each prime is offered with a
// valid/ready handshake and the run ends with a one-cycle done pulse.
// Optional feature: define PRIME_GEN_COUNT_EN to build the accepted-prime
// counter; without it the count port is tied to zero.
`timescale 1ns/1ps

module prime_gen (
  input logic       clk,
  input logic       rst,
  prime_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    NEXT,
    CHECK,
    MOD,
    EMIT,
    DONE
  } state_t;

  state_t      state, state_n;

  // Candidate, divisor and remainder are 10 bits so the candidate can step
  // past a limit of 511 without wrapping back into range.
  logic [9:0]  cand, cand_n;
  logic [9:0]  d, d_n;
  logic [9:0]  r, r_n;
  logic [8:0]  lim, lim_n;
  logic [8:0]  prime_q, prime_n;

  // Full-width square of the divisor; it can never truncate.
  logic [19:0] dsq;
  logic        accept;

  assign dsq    = {10'd0, d} * {10'd0, d};
  assign accept = (state == EMIT) && bus.ready;

  assign bus.valid = (state == EMIT);
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.prime = prime_q;

  // Next-state and datapath update: everything holds unless the state says otherwise.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    d_n     = d;
    r_n     = r;
    lim_n   = lim;
    prime_n = prime_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          lim_n   = bus.limit;
          cand_n  = 10'd2;
          state_n = NEXT;
        end
      end
      NEXT: begin
        if (cand > {1'b0, lim}) begin
          state_n = DONE;
        end else begin
          d_n     = 10'd2;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (dsq > {10'd0, cand}) begin
          // No divisor up to sqrt(candidate) divided it, so it is prime.
          // The candidate is at most the 9-bit limit here, so bit 9 is zero.
          prime_n = cand[8:0];
          state_n = EMIT;
        end else begin
          r_n     = cand;
          state_n = MOD;
        end
      end
      MOD: begin
        if (r >= d) begin
          r_n = r - d;
        end else if (r == 10'd0) begin
          cand_n  = cand + 10'd1;
          state_n = NEXT;
        end else begin
          d_n     = d + 10'd1;
          state_n = CHECK;
        end
      end
      EMIT: begin
        if (bus.ready) begin
          cand_n  = cand + 10'd1;
          state_n = NEXT;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cand    <= 10'd0;
      d       <= 10'd0;
      r       <= 10'd0;
      lim     <= 9'd0;
      prime_q <= 9'd0;
    end else begin
      state   <= state_n;
      cand    <= cand_n;
      d       <= d_n;
      r       <= r_n;
      lim     <= lim_n;
      prime_q <= prime_n;
    end
  end

`ifdef PRIME_GEN_COUNT_EN
  logic [6:0] count_q;

  // Accepted-prime counter: cleared by an accepted start, held after the run ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 7'd0;
    end else if ((state == IDLE) && bus.start) begin
      count_q <= 7'd0;
    end else if (accept) begin
      count_q <= count_q + 7'd1;
    end
  end

  assign bus.count = count_q;
`else
  logic unused_accept;

  assign unused_accept = accept;
  assign bus.count     = 7'd0;
`endif

endmodule

// File: tb/tb_prime_gen.sv
// Self-checking bench for prime_gen. Expected primes come from a bench-side
// trial-division model and are queued when a run is started; the monitor
// pops and compares one entry for every handshake the DUT completes.
`timescale 1ns/1ps

module tb_prime_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;

  prime_gen_if bus ();

  prime_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef PRIME_GEN_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int checks   = 0;
  int errors   = 0;
  int exp_q[$];
  int acc_cnt  = 0;
  int done_cnt = 0;
  int last_acc = 0;
  int exp_v;

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k * k <= n; k++) begin
      if (n % k == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [6:0] exp_count(input int n);
    return CNT_EN ? 7'(n) : 7'd0;
  endfunction

  // Monitor: counts done pulses and scoreboards every accepted prime.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) done_cnt++;
      if (bus.valid && bus.ready) begin
        acc_cnt++;
        last_acc = int'(bus.prime);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_extra got=%0d expected=none", bus.prime);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.prime !== 9'(exp_v)) begin
            errors++;
            $display("[TB] FAIL sb_prime got=%0d expected=%0d", bus.prime, exp_v);
          end
        end
      end
    end
  end

  task automatic start_run(input int lim);
    @(posedge clk); #1;
    for (int p = 2; p <= lim; p++) begin
      if (is_prime(p)) exp_q.push_back(p);
    end
    bus.limit = 9'(lim);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s_timeout got=no_done expected=done within %0d cycles", tag, budget);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_prime(input int value, input int budget, input string tag, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus.valid && bus.prime == 9'(value)) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s_find got=absent expected=prime %0d", tag, value);
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.limit = 9'd0;
    bus.ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.prime, bus.valid, bus.busy, bus.done, bus.count} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL reset_async got=%h expected=0",
               {bus.prime, bus.valid, bus.busy, bus.done, bus.count});
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle got=busy%b valid%b expected=busy0 valid0", bus.busy, bus.valid);
    end
  endtask

  task automatic test_basic;
    int a0;
    int d0;
    a0 = acc_cnt;
    d0 = done_cnt;
    bus.ready = 1'b1;
    start_run(10);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_busy got=%b expected=1", bus.busy);
    end
    wait_done(5000, "basic");
    checks++;
    if (acc_cnt - a0 != 4 || exp_q.size() != 0 || last_acc != 7) begin
      errors++;
      $display("[TB] FAIL basic_seq got=%0d primes last %0d expected=4 primes last 7", acc_cnt - a0, last_acc);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("[TB] FAIL basic_done got=%0d expected=1", done_cnt - d0);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.count !== exp_count(4) || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_count got=%0d busy%b expected=%0d busy0", bus.count, bus.busy, exp_count(4));
    end
  endtask

  task automatic test_small_limit;
    int lims[2];
    int a0;
    lims[0] = 1;
    lims[1] = 0;
    for (int i = 0; i < 2; i++) begin
      a0 = acc_cnt;
      bus.ready = 1'b1;
      @(posedge clk); #1;
      bus.limit = 9'(lims[i]);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL small%0d_c1 got=busy%b done%b expected=busy1 done0", lims[i], bus.busy, bus.done);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b1 || bus.valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL small%0d_c2 got=done%b valid%b expected=done1 valid0", lims[i], bus.done, bus.valid);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || acc_cnt != a0 || bus.count !== exp_count(0)) begin
        errors++;
        $display("[TB] FAIL small%0d_end got=done%b busy%b acc%0d count%0d expected=0 0 0 0",
                 lims[i], bus.done, bus.busy, acc_cnt - a0, bus.count);
      end
    end
  endtask

  task automatic test_stall;
    int  a0;
    bit  seen;
    a0 = acc_cnt;
    bus.ready = 1'b1;
    start_run(20);
    wait_prime(3, 2000, "stall", seen);
    if (seen) begin
      bus.ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        checks++;
        if (bus.valid !== 1'b1 || bus.prime !== 9'd3) begin
          errors++;
          $display("[TB] FAIL stall_hold%0d got=valid%b prime%0d expected=valid1 prime3", i, bus.valid, bus.prime);
        end
      end
      bus.ready = 1'b1;
    end
    wait_done(10000, "stall");
    checks++;
    if (acc_cnt - a0 != 8 || exp_q.size() != 0 || last_acc != 19) begin
      errors++;
      $display("[TB] FAIL stall_seq got=%0d primes last %0d expected=8 primes last 19", acc_cnt - a0, last_acc);
    end
    checks++;
    if (bus.count !== exp_count(8)) begin
      errors++;
      $display("[TB] FAIL stall_count got=%0d expected=%0d", bus.count, exp_count(8));
    end
  endtask

  task automatic test_full_range;
    int a0;
    int d0;
    a0 = acc_cnt;
    d0 = done_cnt;
    bus.ready = 1'b1;
    start_run(511);
    wait_done(400000, "full");
    checks++;
    if (acc_cnt - a0 != 97 || exp_q.size() != 0 || last_acc != 509) begin
      errors++;
      $display("[TB] FAIL full_seq got=%0d primes last %0d expected=97 primes last 509", acc_cnt - a0, last_acc);
    end
    checks++;
    if (done_cnt - d0 != 1 || bus.count !== exp_count(97)) begin
      errors++;
      $display("[TB] FAIL full_end got=done%0d count%0d expected=done1 count%0d", done_cnt - d0, bus.count, exp_count(97));
    end
  endtask

  task automatic test_back_to_back;
    int  a0;
    int  d0;
    bit  seen;
    a0 = acc_cnt;
    d0 = done_cnt;
    bus.ready = 1'b1;
    start_run(30);
    repeat (6) @(posedge clk);
    #1;
    bus.limit = 9'd5;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_prime(5, 2000, "b2b", seen);
    if (seen) begin
      bus.limit = 9'd3;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    wait_done(10000, "b2b");
    checks++;
    if (acc_cnt - a0 != 10 || exp_q.size() != 0 || last_acc != 29) begin
      errors++;
      $display("[TB] FAIL b2b_seq got=%0d primes last %0d expected=10 primes last 29", acc_cnt - a0, last_acc);
    end
    checks++;
    if (done_cnt - d0 != 1 || bus.count !== exp_count(10) || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_end got=done%0d count%0d busy%b expected=done1 count%0d busy0",
               done_cnt - d0, bus.count, bus.busy, exp_count(10));
    end
  endtask

  task automatic test_reset_midrun;
    int  a0;
    int  d0;
    bit  seen;
    bus.ready = 1'b1;
    start_run(50);
    wait_prime(7, 2000, "rstmid", seen);
    bus.ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.prime, bus.valid, bus.busy, bus.done, bus.count} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL rstmid_zero got=%h expected=0",
               {bus.prime, bus.valid, bus.busy, bus.done, bus.count});
    end
    exp_q.delete();
    a0 = acc_cnt;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    bus.ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (acc_cnt != a0 || done_cnt != d0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_quiet got=acc%0d done%0d busy%b expected=0 0 0", acc_cnt - a0, done_cnt - d0, bus.busy);
    end
    start_run(5);
    wait_done(2000, "rstmid");
    checks++;
    if (acc_cnt - a0 != 3 || exp_q.size() != 0 || last_acc != 5 || bus.count !== exp_count(3)) begin
      errors++;
      $display("[TB] FAIL rstmid_rerun got=%0d primes last %0d count %0d expected=3 primes last 5 count %0d",
               acc_cnt - a0, last_acc, bus.count, exp_count(3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small_limit();
    test_stall();
    test_back_to_back();
    test_reset_midrun();
    test_full_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
